// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the MIPS datapath.
// Build macro ILLEGAL_TRAP_EN adds a HALT state (code 5) and the sticky illegal_o port.
module multicycle_ctrl #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       op,
   input  logic [5:0]       funct,
   input  logic [4:0]       rt,
   input  logic             Zero,
   input  logic             Sign,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   output logic             imem_req,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic             ir_we,
   output logic             rf_we,
   output logic             pc_we,
   output logic [1:0]       npc_sel,
   output logic [2:0]       state_o,
   output logic             mem_err,
   output logic [CNT_W-1:0] retire_cnt
`ifdef ILLEGAL_TRAP_EN
   ,
   output logic             illegal_o
`endif
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
`ifdef ILLEGAL_TRAP_EN
      ,
      S_HALT   = 3'd5
`endif
   } state_e;

   typedef enum logic [3:0] {
      C_ILLEGAL, C_BRANCH, C_J, C_JR, C_LOAD, C_STORE, C_ALU, C_JAL, C_JALR
   } cls_e;

   // The wait counter only has to reach TIMEOUT-1; expiry is detected on that count.
   localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_e              state_q, state_d;
   cls_e                cls_q, cls_d, cls_dec;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic                mem_err_q, mem_err_d;
   logic [CNT_W-1:0]    retire_q, retire_d;
   logic                taken;
   logic                wait_hit;

   // Instruction classification from the registered IR fields.
   always_comb begin
      cls_dec = C_ILLEGAL;
      case (op)
         6'h00: begin
            case (funct)
               6'h08: cls_dec = C_JR;
               6'h09: cls_dec = C_JALR;
               6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
               6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
               6'h26, 6'h27, 6'h2a, 6'h2b: cls_dec = C_ALU;
               default: cls_dec = C_ILLEGAL;
            endcase
         end
         6'h01:                      cls_dec = (rt[4:1] == 4'd0) ? C_BRANCH : C_ILLEGAL;
         6'h02:                      cls_dec = C_J;
         6'h03:                      cls_dec = C_JAL;
         6'h04, 6'h05, 6'h06, 6'h07: cls_dec = C_BRANCH;
         6'h08, 6'h09, 6'h0a, 6'h0b,
         6'h0c, 6'h0d, 6'h0e, 6'h0f: cls_dec = C_ALU;
         6'h20, 6'h21, 6'h23,
         6'h24, 6'h25:               cls_dec = C_LOAD;
         6'h28, 6'h29, 6'h2b:        cls_dec = C_STORE;
         default:                    cls_dec = C_ILLEGAL;
      endcase
   end

   always_comb begin
      case (op)
         6'h04:   taken = Zero;
         6'h05:   taken = ~Zero;
         6'h06:   taken = Sign | Zero;
         6'h07:   taken = ~Sign & ~Zero;
         6'h01:   taken = rt[0] ? ~Sign : Sign;
         default: taken = 1'b0;
      endcase
   end

   // NOTE: every output and next-state value gets a default first so no path infers a latch.
   always_comb begin
      state_d   = state_q;
      cls_d     = cls_q;
      wait_d    = '0;
      mem_err_d = mem_err_q;
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      ir_we     = 1'b0;
      rf_we     = 1'b0;
      pc_we     = 1'b0;
      npc_sel   = 2'b00;
      wait_hit  = (TIMEOUT != 0) && (wait_q == WAIT_LAST);

      case (state_q)
         S_FETCH: begin
            imem_req = 1'b1;
            ir_we    = imem_ready;
            if (imem_ready) begin
               state_d = S_DECODE;
            end else if (wait_hit) begin
               mem_err_d = 1'b1;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         S_DECODE: begin
            cls_d   = cls_dec;
            state_d = S_EXEC;
`ifdef ILLEGAL_TRAP_EN
            if (cls_dec == C_ILLEGAL) state_d = S_HALT;
`endif
         end
         S_EXEC: begin
            state_d = S_FETCH;
            case (cls_q)
               C_BRANCH: begin
                  pc_we   = 1'b1;
                  npc_sel = taken ? 2'b01 : 2'b00;
               end
               C_J: begin
                  pc_we   = 1'b1;
                  npc_sel = 2'b10;
               end
               C_JR: begin
                  pc_we   = 1'b1;
                  npc_sel = 2'b11;
               end
               C_LOAD, C_STORE:     state_d = S_MEM;
               C_ALU, C_JAL, C_JALR: state_d = S_WB;
               // Undecoded instructions retire as a NOP.
               default:             pc_we = 1'b1;
            endcase
         end
         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = (cls_q == C_STORE);
            if (dmem_ready) begin
               if (cls_q == C_STORE) begin
                  pc_we   = 1'b1;
                  state_d = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end else if (wait_hit) begin
               mem_err_d = 1'b1;
               state_d   = S_FETCH;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         S_WB: begin
            rf_we   = 1'b1;
            pc_we   = 1'b1;
            npc_sel = (cls_q == C_JAL) ? 2'b10 : (cls_q == C_JALR) ? 2'b11 : 2'b00;
            state_d = S_FETCH;
         end
`ifdef ILLEGAL_TRAP_EN
         S_HALT: state_d = S_HALT;
`endif
         default: state_d = S_FETCH;
      endcase

      // Strobes are forced low while reset is applied, without waiting for a clock.
      if (rst) begin
         imem_req = 1'b0;
         dmem_req = 1'b0;
         dmem_we  = 1'b0;
         ir_we    = 1'b0;
         rf_we    = 1'b0;
         pc_we    = 1'b0;
         npc_sel  = 2'b00;
      end

      retire_d = retire_q + CNT_W'(pc_we);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_FETCH;
         cls_q     <= C_ILLEGAL;
         wait_q    <= '0;
         mem_err_q <= 1'b0;
         retire_q  <= '0;
      end else begin
         state_q   <= state_d;
         cls_q     <= cls_d;
         wait_q    <= wait_d;
         mem_err_q <= mem_err_d;
         retire_q  <= retire_d;
      end
   end

`ifdef ILLEGAL_TRAP_EN
   logic illegal_q, illegal_d;

   always_comb begin
      illegal_d = illegal_q | ((state_q == S_DECODE) && (cls_dec == C_ILLEGAL));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) illegal_q <= 1'b0;
      else     illegal_q <= illegal_d;
   end

   assign illegal_o = illegal_q;
`endif

   assign state_o    = state_q;
   assign mem_err    = mem_err_q;
   assign retire_cnt = retire_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected output vectors are queued as
// stimulus is driven and popped at the falling edge; TIMEOUT=4, CNT_W=4 to reach the limits.
module tb_multicycle_ctrl;
   localparam int TMO = 4;
   localparam int CW  = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [5:0]    op, funct;
   logic [4:0]    rt;
   logic          Zero, Sign, imem_ready, dmem_ready;
   logic          imem_req, dmem_req, dmem_we, ir_we, rf_we, pc_we, mem_err;
   logic [1:0]    npc_sel;
   logic [2:0]    state_o;
   logic [CW-1:0] retire_cnt;
`ifdef ILLEGAL_TRAP_EN
   logic          illegal_o;
`endif

   always #5 clk = ~clk;

   multicycle_ctrl #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .op(op), .funct(funct), .rt(rt), .Zero(Zero), .Sign(Sign),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we), .rf_we(rf_we),
      .pc_we(pc_we), .npc_sel(npc_sel), .state_o(state_o), .mem_err(mem_err),
      .retire_cnt(retire_cnt)
`ifdef ILLEGAL_TRAP_EN
      , .illegal_o(illegal_o)
`endif
   );

   typedef struct packed {
      logic [2:0] st;
      logic       ireq, dreq, dwe, irwe, rfwe, pcwe;
      logic [1:0] nsel;
   } obs_t;

   typedef enum int { K_BR, K_JMP, K_LOAD, K_STORE, K_WB } kind_e;

   obs_t          exp_q[$];
   int            n_vec = 0;
   int            n_err = 0;
   logic [CW-1:0] exp_ret;
   logic          exp_err;
   logic          spur;

   function automatic obs_t mk(input logic [2:0] st, input logic ireq, input logic dreq,
                               input logic dwe, input logic irwe, input logic rfwe,
                               input logic pcwe, input logic [1:0] nsel);
      mk = '{st, ireq, dreq, dwe, irwe, rfwe, pcwe, nsel};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      assert (got === want) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, want);
      end
   endtask

   // One clock: drive readies, queue the expected outputs, compare at the falling edge.
   task automatic cycle(input logic ir, input logic dr, input obs_t e, input string tag);
      obs_t got, want;
      imem_ready = ir;
      dmem_ready = dr;
      exp_q.push_back(e);
      @(negedge clk);
      got  = '{state_o, imem_req, dmem_req, dmem_we, ir_we, rf_we, pc_we, npc_sel};
      want = exp_q.pop_front();
      chk(tag, 32'(got), 32'(want));
      @(posedge clk);
      #1;
   endtask

   task automatic end_check(input string tag);
      chk({tag, "/retire"}, 32'(retire_cnt), 32'(exp_ret));
      chk({tag, "/mem_err"}, 32'(mem_err), 32'(exp_err));
   endtask

   // iw/dw: not-ready cycles before ready; a value >= TMO never answers (timeout path).
   task automatic run(input string tag, input logic [5:0] o, input logic [5:0] f,
                      input logic [4:0] r, input logic z, input logic s,
                      input int iw, input int dw, input kind_e k, input logic [1:0] ns);
      logic we;
      op = o; funct = f; rt = r; Zero = z; Sign = s;
      for (int i = 0; i < iw && i < TMO; i++)
         cycle(1'b0, spur, mk(3'd0, 1, 0, 0, 0, 0, 0, 2'b00), {tag, "/fetch_wait"});
      if (iw >= TMO) begin
         exp_err = 1'b1;
         end_check(tag);
         return;
      end
      cycle(1'b1, spur, mk(3'd0, 1, 0, 0, 1, 0, 0, 2'b00), {tag, "/fetch"});
      cycle(spur, spur, mk(3'd1, 0, 0, 0, 0, 0, 0, 2'b00), {tag, "/decode"});
      case (k)
         K_BR, K_JMP: begin
            cycle(spur, spur, mk(3'd2, 0, 0, 0, 0, 0, 1, ns), {tag, "/exec"});
            exp_ret = exp_ret + 1'b1;
         end
         K_WB: begin
            cycle(spur, spur, mk(3'd2, 0, 0, 0, 0, 0, 0, 2'b00), {tag, "/exec"});
            cycle(spur, spur, mk(3'd4, 0, 0, 0, 0, 1, 1, ns), {tag, "/wb"});
            exp_ret = exp_ret + 1'b1;
         end
         default: begin
            we = (k == K_STORE);
            cycle(spur, spur, mk(3'd2, 0, 0, 0, 0, 0, 0, 2'b00), {tag, "/exec"});
            for (int i = 0; i < dw && i < TMO; i++)
               cycle(spur, 1'b0, mk(3'd3, 0, 1, we, 0, 0, 0, 2'b00), {tag, "/mem_wait"});
            if (dw >= TMO) begin
               exp_err = 1'b1;
            end else begin
               cycle(spur, 1'b1, mk(3'd3, 0, 1, we, 0, 0, we, 2'b00), {tag, "/mem"});
               if (!we) cycle(spur, spur, mk(3'd4, 0, 0, 0, 0, 1, 1, 2'b00), {tag, "/wb"});
               exp_ret = exp_ret + 1'b1;
            end
         end
      endcase
      end_check(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; op = '0; funct = '0; rt = '0; Zero = 1'b0; Sign = 1'b0;
      imem_ready = 1'b0; dmem_ready = 1'b0; spur = 1'b0;
      exp_ret = '0; exp_err = 1'b0;
      #1;
      chk("reset/outputs", 32'({state_o, imem_req, dmem_req, dmem_we, ir_we, rf_we, pc_we, npc_sel}), 32'd0);
      end_check("reset");
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;

      // Basic classes with zero-wait memory.
      run("addu",      6'h00, 6'h21, 5'd0, 0, 0, 0, 0, K_WB,    2'b00);
      run("lw_waits",  6'h23, 6'h00, 5'd0, 0, 0, 3, 2, K_LOAD,  2'b00);
      run("beq_t",     6'h04, 6'h00, 5'd0, 1, 0, 0, 0, K_BR,    2'b01);
      run("bne_nt",    6'h05, 6'h00, 5'd0, 1, 0, 0, 0, K_BR,    2'b00);
      run("blez_t",    6'h06, 6'h00, 5'd0, 0, 1, 0, 0, K_BR,    2'b01);
      run("bgtz_nt",   6'h07, 6'h00, 5'd0, 1, 0, 0, 0, K_BR,    2'b00);
      run("bgtz_t",    6'h07, 6'h00, 5'd0, 0, 0, 0, 0, K_BR,    2'b01);
      run("bltz_t",    6'h01, 6'h00, 5'd0, 0, 1, 0, 0, K_BR,    2'b01);
      run("bgez_nt",   6'h01, 6'h00, 5'd1, 0, 1, 0, 0, K_BR,    2'b00);
      run("j",         6'h02, 6'h00, 5'd0, 0, 0, 0, 0, K_JMP,   2'b10);
      run("jr",        6'h00, 6'h08, 5'd0, 0, 0, 0, 0, K_JMP,   2'b11);
      run("jal",       6'h03, 6'h00, 5'd0, 0, 0, 0, 0, K_WB,    2'b10);
      run("jalr",      6'h00, 6'h09, 5'd0, 0, 0, 0, 0, K_WB,    2'b11);

      // Readies raised while the matching request is low must be ignored.
      spur = 1'b1;
      run("lui_spur",  6'h0f, 6'h00, 5'd0, 0, 0, 0, 0, K_WB,    2'b00);
      run("sw_spur",   6'h2b, 6'h00, 5'd0, 0, 0, 0, 0, K_STORE, 2'b00);
      spur = 1'b0;

      // Ready arriving on the expiry cycle wins; then data and fetch timeouts.
      run("lh_edge",   6'h21, 6'h00, 5'd0, 0, 0, 3, 3, K_LOAD,  2'b00);
      run("sw_tmo",    6'h2b, 6'h00, 5'd0, 0, 0, 0, 9, K_STORE, 2'b00);
      run("addu_ftmo", 6'h00, 6'h21, 5'd0, 0, 0, 9, 0, K_WB,    2'b00);
      run("addu_post", 6'h00, 6'h21, 5'd0, 0, 0, 0, 0, K_WB,    2'b00);

      // Asynchronous reset while a store waits in MEM; a late ready must not matter.
      op = 6'h2b; funct = '0; rt = '0;
      cycle(1'b1, 1'b0, mk(3'd0, 1, 0, 0, 1, 0, 0, 2'b00), "rst_mid/fetch");
      cycle(1'b0, 1'b0, mk(3'd1, 0, 0, 0, 0, 0, 0, 2'b00), "rst_mid/decode");
      cycle(1'b0, 1'b0, mk(3'd2, 0, 0, 0, 0, 0, 0, 2'b00), "rst_mid/exec");
      cycle(1'b0, 1'b0, mk(3'd3, 0, 1, 1, 0, 0, 0, 2'b00), "rst_mid/mem");
      rst = 1'b1;
      #1;
      exp_ret = '0; exp_err = 1'b0;
      chk("rst_mid/outputs", 32'({state_o, imem_req, dmem_req, dmem_we, ir_we, rf_we, pc_we, npc_sel}), 32'd0);
      end_check("rst_mid");
      dmem_ready = 1'b1;
      @(posedge clk); #1;
      chk("rst_mid/held", 32'({state_o, dmem_req, pc_we}), 32'd0);
      rst = 1'b0;
      spur = 1'b1;
      run("addu_late", 6'h00, 6'h21, 5'd0, 0, 0, 0, 0, K_WB,    2'b00);
      spur = 1'b0;

      // Retired-instruction counter wraps at 2^CW.
      for (int i = 0; i < 16; i++)
         run("j_wrap",  6'h02, 6'h00, 5'd0, 0, 0, 0, 0, K_JMP,   2'b10);

`ifdef ILLEGAL_TRAP_EN
      op = 6'h3f; funct = '0; rt = '0;
      cycle(1'b1, 1'b0, mk(3'd0, 1, 0, 0, 1, 0, 0, 2'b00), "illegal/fetch");
      cycle(1'b0, 1'b0, mk(3'd1, 0, 0, 0, 0, 0, 0, 2'b00), "illegal/decode");
      for (int i = 0; i < 3; i++)
         cycle(1'b1, 1'b1, mk(3'd5, 0, 0, 0, 0, 0, 0, 2'b00), "illegal/halt");
      chk("illegal/flag", 32'(illegal_o), 32'd1);
      end_check("illegal");
      rst = 1'b1;
      #1;
      rst = 1'b0;
      exp_ret = '0;
      chk("illegal/cleared", 32'({illegal_o, state_o}), 32'd0);
      end_check("illegal_rst");
`else
      run("undef_op",    6'h3f, 6'h00, 5'd0, 0, 0, 0, 0, K_JMP, 2'b00);
      run("undef_funct", 6'h00, 6'h3f, 5'd0, 0, 0, 0, 0, K_JMP, 2'b00);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
